// File: rtl/load_store_unit.sv
// Load/store unit: aligns CPU byte/half/word accesses onto a 32-bit word memory
// port, flags misaligned or illegal sizes, and extends load results.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_legal;
    logic [3:0]  req_be;
    logic [31:0] req_wdata_rep;
    logic [31:0] rdata_shifted;
    logic [31:0] load_ext;

    // Request decode: legality, lane enables and lane-replicated store data.
    always_comb begin
        req_legal     = 1'b0;
        req_be        = 4'b0000;
        req_wdata_rep = 32'd0;
        case (req_size)
            2'b00: begin
                req_legal     = 1'b1;
                req_be        = 4'b0001 << req_addr[1:0];
                req_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_legal     = ~req_addr[0];
                req_be        = 4'b0011 << req_addr[1:0];
                req_wdata_rep = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                req_legal     = (req_addr[1:0] == 2'b00);
                req_be        = 4'b1111;
                req_wdata_rep = req_wdata;
            end
            default: begin
                req_legal     = 1'b0;
                req_be        = 4'b0000;
                req_wdata_rep = 32'd0;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend by size.
    assign rdata_shifted = mem_rdata >> {offset_q, 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   load_ext = {{24{sign_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'b01:   load_ext = {{16{sign_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            sign_q   <= 1'b0;
            offset_q <= 2'b00;
            addr_q   <= 32'd0;
            be_q     <= 4'b0000;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            sign_q   <= sign_d;
            offset_q <= offset_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = req_legal ? S_WAIT : S_RESP;
            S_WAIT:  if (mem_ack) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields are captured only on acceptance; load data only on ack.
    always_comb begin
        we_d     = we_q;
        size_d   = size_q;
        sign_d   = sign_q;
        offset_d = offset_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        if (state_q == S_IDLE && req_valid) begin
            we_d     = req_we;
            size_d   = req_size;
            sign_d   = req_sign;
            offset_d = req_addr[1:0];
            addr_d   = {req_addr[31:2], 2'b00};
            be_d     = req_be;
            wdata_d  = req_wdata_rep;
            err_d    = ~req_legal;
            rdata_d  = 32'd0;
        end else if (state_q == S_WAIT && mem_ack && !we_q) begin
            rdata_d  = load_ext;
        end
    end

    // All outputs decode from the state, so reset clears them without a clock.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        mem_req    = (state_q == S_WAIT);
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_be     = 4'b0000;
        mem_wdata  = 32'd0;
        resp_valid = (state_q == S_RESP);
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        if (state_q == S_WAIT) begin
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_be    = be_q;
            mem_wdata = wdata_q;
        end
        if (state_q == S_RESP) begin
            resp_rdata = rdata_q;
            resp_err   = err_q;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit: lane mapping, extension, errors,
// ack stalls, ignored requests and reset abandonment.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          guard;
        logic [31:0] exp_addr;
        exp_addr = {v.addr[31:2], 2'b00};
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk($sformatf("v%0d ready_before_req", idx), {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_size  = v.size;
        req_sign  = v.sign;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        if (v.exp_err) begin
            chk($sformatf("v%0d err_mem_req", idx), {31'd0, mem_req}, 32'd0);
            chk($sformatf("v%0d err_resp_valid", idx), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("v%0d err_resp_err", idx), {31'd0, resp_err}, 32'd1);
            chk($sformatf("v%0d err_resp_rdata", idx), resp_rdata, 32'd0);
            chk($sformatf("v%0d err_ready_busy", idx), {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d err_ready_back", idx), {31'd0, req_ready}, 32'd1);
            chk($sformatf("v%0d err_resp_drop", idx), {31'd0, resp_valid}, 32'd0);
            $display("vec %0d: addr=%h size=%0d -> error response", idx, v.addr, v.size);
        end else begin
            chk($sformatf("v%0d mem_req", idx), {31'd0, mem_req}, 32'd1);
            chk($sformatf("v%0d mem_we", idx), {31'd0, mem_we}, {31'd0, v.we});
            chk($sformatf("v%0d mem_addr", idx), mem_addr, exp_addr);
            chk($sformatf("v%0d mem_be", idx), {28'd0, mem_be}, {28'd0, v.exp_be});
            if (v.we) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.exp_wdata);
            chk($sformatf("v%0d ready_busy", idx), {31'd0, req_ready}, 32'd0);
            for (int k = 0; k < v.delay; k++) begin
                // A competing request while busy must be ignored.
                req_valid = 1'b1;
                req_addr  = 32'hFFFF_FFF0;
                req_size  = 2'b10;
                @(negedge clk);
                chk($sformatf("v%0d stall%0d mem_req", idx, k), {31'd0, mem_req}, 32'd1);
                chk($sformatf("v%0d stall%0d mem_addr", idx, k), mem_addr, exp_addr);
                chk($sformatf("v%0d stall%0d mem_be", idx, k), {28'd0, mem_be}, {28'd0, v.exp_be});
                chk($sformatf("v%0d stall%0d resp_valid", idx, k), {31'd0, resp_valid}, 32'd0);
                chk($sformatf("v%0d stall%0d ready", idx, k), {31'd0, req_ready}, 32'd0);
            end
            req_valid = 1'b0;
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'h5A5A_5A5A;
            chk($sformatf("v%0d resp_valid", idx), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("v%0d resp_rdata", idx), resp_rdata, v.exp_rdata);
            chk($sformatf("v%0d resp_err", idx), {31'd0, resp_err}, 32'd0);
            chk($sformatf("v%0d mem_req_after_ack", idx), {31'd0, mem_req}, 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d resp_drop", idx), {31'd0, resp_valid}, 32'd0);
            chk($sformatf("v%0d resp_rdata_idle", idx), resp_rdata, 32'd0);
            chk($sformatf("v%0d ready_back", idx), {31'd0, req_ready}, 32'd1);
            $display("vec %0d: we=%0d size=%0d addr=%h be=%b resp_rdata=%h", idx, v.we, v.size, v.addr, v.exp_be, v.exp_rdata);
        end
    endtask

    initial begin
        //          we    size   sign  addr          wdata         rdata         dly err  be       exp_wdata     exp_rdata
        vecs[0]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00A5, 32'h0,        0, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0102, 32'h0,        32'h0080_0000, 0, 1'b0, 4'b0100, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0,        32'h0080_0000, 0, 1'b0, 4'b0100, 32'h0,        32'h0000_0080};
        vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0,        32'h8001_FFFF, 1, 1'b0, 4'b1100, 32'h0,        32'h0000_8001};
        vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0301, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[5]  = '{1'b0, 2'b10, 1'b1, 32'h0000_0400, 32'h0,        32'hDEAD_BEEF, 5, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h1234_BEEF, 32'h0,        0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0,        32'h0000_8765, 0, 1'b0, 4'b0011, 32'h0,        32'hFFFF_8765};
        vecs[8]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h0000_1111, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[10] = '{1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0,        2, 1'b0, 4'b1111, 32'h1122_3344, 32'h0};
        vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0,        32'h0000_FE00, 0, 1'b0, 4'b0010, 32'h0,        32'h0000_00FE};
        vecs[12] = '{1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0,        32'h7F00_0000, 0, 1'b0, 4'b1000, 32'h0,        32'h0000_007F};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b00;
        req_sign  = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;

        #3;
        chk("reset ready", {31'd0, req_ready}, 32'd1);
        chk("reset mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset mem_be", {28'd0, mem_be}, 32'd0);
        $display("reset: ready=%0d mem_req=%0d resp_valid=%0d", req_ready, mem_req, resp_valid);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // A stray ack while idle must not produce a response.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("idle_ack ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

        // Reset during WAIT abandons the access with no response.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h0000_0500;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstwait mem_req_before", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rstwait mem_req_drop", {31'd0, mem_req}, 32'd0);
        chk("rstwait ready", {31'd0, req_ready}, 32'd1);
        chk("rstwait mem_addr", mem_addr, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rstwait no_resp%0d", k), {31'd0, resp_valid}, 32'd0);
            chk($sformatf("rstwait idle%0d", k), {31'd0, req_ready}, 32'd1);
        end
        mem_ack = 1'b0;
        $display("reset in WAIT: access abandoned");
        run_vec(vecs[1], 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
